// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic parking-bay scanner.
// Timing defaults assume a 50 MHz system clock.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      GAP
   } scan_state_e;

   localparam int DEF_TRIG_CYCLES  = 500;
   localparam int DEF_ECHO_TIMEOUT = 1_900_000;
   localparam int DEF_GAP_CYCLES   = 500_000;
   localparam int DEF_CNT_W        = 22;
   localparam int DEF_OCC_HITS     = 3;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/ultrasonic_scan_ctrl_occ_debounce.sv
// Per-bay occupancy debounce: the flag flips only after OCC_HITS consecutive
// samples that disagree with it.
module occ_debounce
   import ultrasonic_pkg::*;
#(
   parameter int OCC_HITS = DEF_OCC_HITS
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic sample_valid,
   input  logic near,
   output logic occupied,
   output logic occupied_next
);

   localparam int HIT_W = $clog2(OCC_HITS + 1);

   logic [HIT_W-1:0] hits_q, hits_d;
   logic             occ_q, occ_d;

   always_comb begin
      hits_d = hits_q;
      occ_d  = occ_q;
      if (sample_valid) begin
         if (near != occ_q) begin
            if (hits_q >= HIT_W'(OCC_HITS - 1)) begin
               occ_d  = ~occ_q;
               hits_d = '0;
            end else begin
               hits_d = hits_q + 1'b1;
            end
         end else begin
            hits_d = '0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         hits_q <= '0;
         occ_q  <= 1'b0;
      end else begin
         hits_q <= hits_d;
         occ_q  <= occ_d;
      end
   end

   assign occupied      = occ_q;
   assign occupied_next = occ_d;

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin HC-SR04 scanner: triggers one sensor at a time, times its echo,
// reports the width and keeps a debounced occupied flag per bay.
module ultrasonic_scan_ctrl
   import ultrasonic_pkg::*;
#(
   parameter int N_SENSORS    = 4,
   parameter int IDX_W        = 2,
   parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
   parameter int ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int OCC_HITS     = DEF_OCC_HITS
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] echo,
   input  logic [CNT_W-1:0]     thresh_cycles,
   output logic [N_SENSORS-1:0] trig,
   output logic [CNT_W-1:0]     dist_cycles,
   output logic [IDX_W-1:0]     dist_id,
   output logic                 dist_valid,
   output logic                 timeout,
   output logic [N_SENSORS-1:0] occupied,
   output logic [3:0]           free_count
);

   localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

   logic [N_SENSORS-1:0] echo_s1_q, echo_s2_q, echo_s3_q;

   scan_state_e          state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d, idx_next;
   logic [TRIG_W-1:0]    trig_cnt_q, trig_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]     to_cnt_q, to_cnt_d, to_inc;
   logic [CNT_W-1:0]     width_cnt_q, width_cnt_d, width_inc;
   logic [N_SENSORS-1:0] trig_q, trig_d;
   logic [CNT_W-1:0]     dist_cycles_q, dist_cycles_d;
   logic [IDX_W-1:0]     dist_id_q, dist_id_d;
   logic                 dist_valid_q, dist_valid_d;
   logic                 timeout_q, timeout_d;
   logic [3:0]           free_count_q, free_count_d;

   logic echo_cur, echo_prev, echo_rise, echo_fall, to_hit;
   logic meas_done, meas_to;
   logic near_sample;
   logic [N_SENSORS-1:0] occ_next;

   assign echo_cur  = echo_s2_q[idx_q];
   assign echo_prev = echo_s3_q[idx_q];
   assign echo_rise = echo_cur & ~echo_prev;
   assign echo_fall = ~echo_cur & echo_prev;
   assign to_hit    = (to_cnt_q == CNT_W'(ECHO_TIMEOUT - 1));
   assign to_inc    = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
   assign width_inc = (width_cnt_q == '1) ? width_cnt_q : width_cnt_q + 1'b1;
   assign idx_next  = (idx_q == IDX_W'(N_SENSORS - 1)) ? '0 : idx_q + 1'b1;

   // The width counter is cleared in the rise cycle, so the fall cycle adds
   // one to account for that first high cycle.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      trig_cnt_d    = trig_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      to_cnt_d      = to_cnt_q;
      width_cnt_d   = width_cnt_q;
      trig_d        = trig_q;
      dist_cycles_d = dist_cycles_q;
      dist_id_d     = dist_id_q;
      dist_valid_d  = 1'b0;
      timeout_d     = 1'b0;
      meas_done     = 1'b0;
      meas_to       = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d        = TRIG;
               trig_cnt_d     = '0;
               trig_d         = '0;
               trig_d[idx_q]  = 1'b1;
            end
         end
         TRIG: begin
            if (trig_cnt_q == TRIG_W'(TRIG_CYCLES - 1)) begin
               trig_d   = '0;
               state_d  = WAIT_RISE;
               to_cnt_d = '0;
            end else begin
               trig_cnt_d = trig_cnt_q + 1'b1;
            end
         end
         WAIT_RISE: begin
            if (echo_rise) begin
               width_cnt_d = '0;
               state_d     = MEASURE;
               to_cnt_d    = to_inc;
            end else if (to_hit) begin
               meas_done = 1'b1;
               meas_to   = 1'b1;
            end else begin
               to_cnt_d = to_inc;
            end
         end
         MEASURE: begin
            if (echo_fall) begin
               meas_done = 1'b1;
            end else if (to_hit) begin
               meas_done = 1'b1;
               meas_to   = 1'b1;
            end else begin
               to_cnt_d = to_inc;
               if (echo_cur) begin
                  width_cnt_d = width_inc;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
               idx_d = idx_next;
               if (enable) begin
                  state_d          = TRIG;
                  trig_cnt_d       = '0;
                  trig_d           = '0;
                  trig_d[idx_next] = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (meas_done) begin
         dist_valid_d  = 1'b1;
         dist_id_d     = idx_q;
         dist_cycles_d = meas_to ? '1 : width_inc;
         timeout_d     = meas_to;
         state_d       = GAP;
         gap_cnt_d     = '0;
      end
   end

   assign near_sample = ~timeout_q && (dist_cycles_q < thresh_cycles);

   for (genvar g = 0; g < N_SENSORS; g++) begin : g_bay
      occ_debounce #(
         .OCC_HITS(OCC_HITS)
      ) u_occ (
         .sys_clk       (sys_clk),
         .sys_rst_n     (sys_rst_n),
         .sample_valid  (dist_valid_q && (dist_id_q == IDX_W'(g))),
         .near          (near_sample),
         .occupied      (occupied[g]),
         .occupied_next (occ_next[g])
      );
   end

   assign free_count_d = 4'(N_SENSORS) - popcount8(8'(occ_next));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         echo_s1_q     <= '0;
         echo_s2_q     <= '0;
         echo_s3_q     <= '0;
         state_q       <= IDLE;
         idx_q         <= '0;
         trig_cnt_q    <= '0;
         gap_cnt_q     <= '0;
         to_cnt_q      <= '0;
         width_cnt_q   <= '0;
         trig_q        <= '0;
         dist_cycles_q <= '0;
         dist_id_q     <= '0;
         dist_valid_q  <= 1'b0;
         timeout_q     <= 1'b0;
         free_count_q  <= 4'(N_SENSORS);
      end else begin
         echo_s1_q     <= echo;
         echo_s2_q     <= echo_s1_q;
         echo_s3_q     <= echo_s2_q;
         state_q       <= state_d;
         idx_q         <= idx_d;
         trig_cnt_q    <= trig_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         to_cnt_q      <= to_cnt_d;
         width_cnt_q   <= width_cnt_d;
         trig_q        <= trig_d;
         dist_cycles_q <= dist_cycles_d;
         dist_id_q     <= dist_id_d;
         dist_valid_q  <= dist_valid_d;
         timeout_q     <= timeout_d;
         free_count_q  <= free_count_d;
      end
   end

   assign trig        = trig_q;
   assign dist_cycles = dist_cycles_q;
   assign dist_id     = dist_id_q;
   assign dist_valid  = dist_valid_q;
   assign timeout     = timeout_q;
   assign free_count  = free_count_q;

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Scoreboard bench for ultrasonic_scan_ctrl: an echo responder plays a plan of
// echo widths and queues expected results; a monitor checks every dist_valid.
module tb_ultrasonic_scan_ctrl;

   localparam int N     = 4;
   localparam int IDX_W = 2;
   localparam int TRIGC = 5;
   localparam int TOC   = 200;
   localparam int GAPC  = 20;
   localparam int CNT_W = 22;
   localparam int HITS  = 2;
   localparam int THR   = 50;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n;
   logic             enable;
   logic [N-1:0]     echo;
   logic [N-1:0]     echo_pulse;
   logic [N-1:0]     stuck;
   logic [CNT_W-1:0] thresh_cycles;
   logic [N-1:0]     trig;
   logic [CNT_W-1:0] dist_cycles;
   logic [IDX_W-1:0] dist_id;
   logic             dist_valid;
   logic             timeout;
   logic [N-1:0]     occupied;
   logic [3:0]       free_count;

   assign echo = echo_pulse | stuck;

   ultrasonic_scan_ctrl #(
      .N_SENSORS    (N),
      .IDX_W        (IDX_W),
      .TRIG_CYCLES  (TRIGC),
      .ECHO_TIMEOUT (TOC),
      .GAP_CYCLES   (GAPC),
      .CNT_W        (CNT_W),
      .OCC_HITS     (HITS)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .enable        (enable),
      .echo          (echo),
      .thresh_cycles (thresh_cycles),
      .trig          (trig),
      .dist_cycles   (dist_cycles),
      .dist_id       (dist_id),
      .dist_valid    (dist_valid),
      .timeout       (timeout),
      .occupied      (occupied),
      .free_count    (free_count)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int  w;
      bit  drop;
   } plan_t;

   typedef struct {
      int               id;
      logic [CNT_W-1:0] cyc;
      bit               to;
      int               fall_cyc;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [N-1:0] occ_m;
   int           hits_m [N];
   bit           occ_pending;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // w < 0 means the line is held high before and during this measurement
   task automatic applyStimulus(input int w, input bit drop);
      plan_t p;
      p.w    = w;
      p.drop = drop;
      plan_q.push_back(p);
   endtask

   // Echo responder: reacts to each trigger fall according to the plan.
   initial begin : responder
      logic [N-1:0] prev_trig;
      logic [N-1:0] fell;
      int           exp_id;
      plan_t        p;
      exp_t         e;
      prev_trig  = '0;
      exp_id     = 0;
      echo_pulse = '0;
      stuck      = '0;
      forever begin
         @(negedge sys_clk);
         fell = prev_trig & ~trig;
         if (fell != '0 && sys_rst_n) begin
            if (plan_q.size() == 0) begin
               checkOutput("unplanned_trig", 32'(fell), 0);
            end else begin
               p = plan_q.pop_front();
               checkOutput("trig_order", 32'(fell), 32'(1) << exp_id);
               e.id       = exp_id;
               e.to       = (p.w < 0);
               e.cyc      = (p.w < 0) ? '1 : CNT_W'(p.w);
               e.fall_cyc = cyc;
               exp_q.push_back(e);
               if (p.w >= 0) stuck = '0;
               if (plan_q.size() > 0 && plan_q[0].w < 0) stuck[(exp_id + 1) % N] = 1'b1;
               if (p.w >= 0) begin
                  repeat (10) @(negedge sys_clk);
                  echo_pulse[exp_id] = 1'b1;
                  for (int k = 0; k < p.w; k++) begin
                     if (p.drop && k == 5) enable = 1'b0;
                     @(negedge sys_clk);
                  end
                  echo_pulse[exp_id] = 1'b0;
               end
               exp_id = (exp_id + 1) % N;
            end
         end
         prev_trig = trig;
      end
   end

   // Trigger shape: never two bits at once, each pulse exactly TRIGC cycles.
   initial begin : trig_mon
      int hi_cnt [N];
      logic [N-1:0] prev;
      prev = '0;
      for (int i = 0; i < N; i++) hi_cnt[i] = 0;
      forever begin
         @(negedge sys_clk);
         checkOutput("trig_onehot", 32'($onehot0(trig)), 1);
         for (int i = 0; i < N; i++) begin
            if (trig[i]) hi_cnt[i]++;
            if (prev[i] && !trig[i]) begin
               if (sys_rst_n) checkOutput("trig_width", hi_cnt[i], TRIGC);
               hi_cnt[i] = 0;
            end
         end
         prev = trig;
      end
   end

   // Scoreboard monitor with a reference occupancy model.
   initial begin : monitor
      exp_t e;
      bit   nr;
      occ_pending = 1'b0;
      occ_m       = '0;
      for (int i = 0; i < N; i++) hits_m[i] = 0;
      forever begin
         @(negedge sys_clk);
         if (occ_pending) begin
            checkOutput("occupied", 32'(occupied), 32'(occ_m));
            checkOutput("free_count", 32'(free_count), N - $countones(occ_m));
            occ_pending = 1'b0;
         end
         if (timeout && !dist_valid) checkOutput("timeout_alone", 1, 0);
         if (dist_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("dist_id", 32'(dist_id), e.id);
               checkOutput("dist_cycles", 32'(dist_cycles), 32'(e.cyc));
               checkOutput("timeout", 32'(timeout), 32'(e.to));
               if (e.to) checkOutput("timeout_latency", cyc - e.fall_cyc, TOC);
               nr = !e.to && (e.cyc < CNT_W'(THR));
               if (nr != occ_m[e.id]) begin
                  hits_m[e.id]++;
                  if (hits_m[e.id] == HITS) begin
                     occ_m[e.id]  = ~occ_m[e.id];
                     hits_m[e.id] = 0;
                  end
               end else begin
                  hits_m[e.id] = 0;
               end
               occ_pending = 1'b1;
            end
         end
      end
   end

   int plan_tbl [24] = '{30, 30, 30, 30,
                         120, 120, 30, 120,
                         120, -1, 120, 120,
                         120, 120, 30, 120,
                         120, 120, 120, 30,
                         120, 120, 120, 30};

   initial begin : main
      int waited;
      int busy;
      sys_rst_n     = 1'b0;
      enable        = 1'b0;
      thresh_cycles = CNT_W'(THR);

      repeat (3) @(posedge sys_clk);
      #1;
      checkOutput("rst_trig", 32'(trig), 0);
      checkOutput("rst_dist_cycles", 32'(dist_cycles), 0);
      checkOutput("rst_dist_id", 32'(dist_id), 0);
      checkOutput("rst_dist_valid", 32'(dist_valid), 0);
      checkOutput("rst_timeout", 32'(timeout), 0);
      checkOutput("rst_occupied", 32'(occupied), 0);
      checkOutput("rst_free_count", 32'(free_count), N);

      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 24; i++) applyStimulus(plan_tbl[i], i == 23);
      enable = 1'b1;

      waited = 0;
      while (waited < 20000 && !(plan_q.size() == 0 && exp_q.size() == 0 && !enable)) begin
         @(negedge sys_clk);
         waited++;
      end
      checkOutput("scan_wait_expired", 32'(waited >= 20000), 0);

      repeat (40) @(negedge sys_clk);
      busy = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge sys_clk);
         if (trig != '0) busy++;
      end
      checkOutput("idle_after_drop", busy, 0);

      enable = 1'b1;
      waited = 0;
      while (waited < 50 && trig == '0) begin
         @(negedge sys_clk);
         waited++;
      end
      checkOutput("restart_trig", 32'(trig), 32'b0001);

      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      enable    = 1'b0;
      @(posedge sys_clk);
      #1;
      checkOutput("midrst_trig", 32'(trig), 0);
      checkOutput("midrst_dist_valid", 32'(dist_valid), 0);
      checkOutput("midrst_occupied", 32'(occupied), 0);
      checkOutput("midrst_free_count", 32'(free_count), N);
      occ_m = '0;
      for (int i = 0; i < N; i++) hits_m[i] = 0;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (60) @(negedge sys_clk);

      checkOutput("sb_empty", exp_q.size(), 0);
      checkOutput("plan_empty", plan_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
